vmem_spike_reset_unit: RTL and testbench
========================================

# vmem_spike_reset_unit

Post-leak threshold stage of the neuron update datapath. Takes each leaked membrane potential and decides fire/no-fire. On a spike it resets the potential to Vreset and loads the refractory counter. Spiking neuron IDs are queued in a small FIFO for the spike router. Sits directly downstream of the leak unit and uses the same signed Qm.n fixed-point format.

## Interface
- INTEGER_WIDTH, 32, integer bits of fixed-point word
- DATA_WIDTH_FRAC, 32, fractional bits
- DATA_WIDTH, INTEGER_WIDTH+DATA_WIDTH_FRAC, full word width
- NEURON_ID_WIDTH, 8, neuron index width
- REFRACT_WIDTH, 8, refractory counter width (timesteps)
- SPIKE_FIFO_DEPTH, 4, spike queue entries (power of two, >=2)

- Clock  in  1  sole clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- Vth  in  INTEGER_WIDTH  signed threshold (integer)
- Vreset  in  INTEGER_WIDTH  signed post-spike potential (integer)
- Tref  in  REFRACT_WIDTH  refractory period loaded on spike
- InValid / InReady  in / out  1  input handshake
- InNeuronID  in  NEURON_ID_WIDTH  neuron index
- InVmem  in  DATA_WIDTH  signed leaked potential
- InRefCount  in  REFRACT_WIDTH  remaining refractory steps
- OutValid / OutReady  out / in  1  result handshake
- OutNeuronID  out  NEURON_ID_WIDTH  echoed index
- OutVmem  out  DATA_WIDTH  updated potential
- OutRefCount  out  REFRACT_WIDTH  updated refractory count
- OutSpike  out  1  neuron fired this update
- SpikeValid / SpikeReady  out / in  1  spike queue handshake
- SpikeNeuronID  out  NEURON_ID_WIDTH  head-of-queue neuron index
- SpikeOverflow  out  1  sticky: spike dropped because the queue was full

## Operation
- The input is accepted on a rising edge when InValid && InReady.
- InReady = !OutValid || OutReady. This gives a single-entry output register with full throughput.
- Integer operands are extended to fixed point by zero-padding the fraction: Vth_ext = {Vth, 0}, Vreset_ext = {Vreset, 0}.
- For each accepted input, the first matching rule applies:
  - Refractory: InRefCount != 0 gives OutVmem = Vreset_ext, OutRefCount = InRefCount-1, OutSpike = 0. No threshold test is made.
  - Fire: signed InVmem >= Vth_ext gives OutVmem = Vreset_ext, OutRefCount = Tref, OutSpike = 1.
  - Otherwise: OutVmem = InVmem, OutRefCount = 0, OutSpike = 0.
- OutNeuronID is always InNeuronID.
- Spike queue behaviour:
  - A fire event pushes InNeuronID in the same edge that the result is registered.
  - Pop happens on SpikeValid && SpikeReady.
  - A push is accepted when the queue is not full, or when it is full and a pop occurs in the same edge.
  - Otherwise the ID is dropped and SpikeOverflow is set. OutSpike is still 1.
- SpikeOverflow clears only on reset.
- The queue is FIFO-ordered. Pointers wrap modulo SPIKE_FIFO_DEPTH, and an occupancy count distinguishes full from empty.

## Timing
- Latency: input accepted at edge N gives OutValid=1 and the result visible after edge N. The spike ID is visible on SpikeValid after edge N if the queue was empty.
- Outputs are held stable while OutValid && !OutReady. Spike outputs are held while SpikeValid && !SpikeReady.
- OutValid drops after an edge with OutReady=1 and no new input.
- Vth, Vreset and Tref are sampled at the accept edge only.
- Reset values (asynchronous, Reset=0):
  - OutValid=0, OutVmem=0, OutRefCount=0, OutSpike=0, OutNeuronID=0.
  - SpikeValid=0, SpikeNeuronID=0, SpikeOverflow=0.
  - Queue empty, pointers 0.
  - InReady=1 once out of reset.
- Reset mid-transaction discards the pending result and all queued spikes.

## Configuration
- REFRACTORY_EN defined: the refractory rule above is active.
- REFRACTORY_EN undefined:
  - InRefCount and Tref are ignored, and OutRefCount is driven constant 0.
  - Fire and pass rules only, so a neuron may fire on consecutive updates.
  - Ports are unchanged.

## Structure
- Shared package holds:
  - width constants and the fixed-point word typedef
  - the int-to-fixed extension function
  - the neuron-update record typedef (ID, Vmem, RefCount, Spike)
- One sub-module, spike_fifo:
  - parameterized by NEURON_ID_WIDTH and SPIKE_FIFO_DEPTH
  - push, pop, full and empty
  - push-when-full-with-pop rule included
- The top level holds the compare/select logic and the output register.

## Test plan
- Basic fire: Vth=10, Vreset=0, Tref=3, InVmem=0x0000000A_00000000, RefCount=0, ID=5 → next cycle OutSpike=1, OutVmem=0, OutRefCount=3; SpikeNeuronID=5, SpikeValid=1.
- Threshold boundaries:
  - InVmem=0x00000009_FFFFFFFF → no spike, OutVmem echoes the input, OutRefCount=0.
  - Vth=-5 with InVmem=0xFFFFFFFB_00000000 → spike (signed compare).
- Refractory: InRefCount=2, InVmem=100.0, Vreset=-3 → OutSpike=0, OutVmem=0xFFFFFFFD_00000000, OutRefCount=1. With REFRACTORY_EN undefined the same input → spike, OutRefCount=0.
- Backpressure: OutReady=0 for 3 cycles with InValid=1 → InReady=0, outputs stable, no input lost; OutReady=1 → back-to-back transfers, one per cycle.
- Queue overflow:
  - SpikeReady=0, 5 consecutive firing IDs 1..5, depth 4 → IDs 1..4 queued, ID 5 dropped, SpikeOverflow=1.
  - Then assert SpikeReady with a firing ID 6 on a cycle where the queue is full → ID 6 accepted, drain order 1,2,3,4,6.
- Async reset: assert Reset=0 mid-cycle while OutValid=1 and the queue is non-empty → OutValid, SpikeValid and SpikeOverflow go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/vmem_spike_reset_unit_pkg.sv
// Shared widths, fixed-point types and helpers for the membrane threshold/reset stage.
// Build option: define REFRACTORY_EN to enable the refractory rule in the top level.
package vmem_spike_reset_unit_pkg;

    localparam int INTEGER_WIDTH    = 32;
    localparam int DATA_WIDTH_FRAC  = 32;
    localparam int DATA_WIDTH       = INTEGER_WIDTH + DATA_WIDTH_FRAC;
    localparam int NEURON_ID_WIDTH  = 8;
    localparam int REFRACT_WIDTH    = 8;
    localparam int SPIKE_FIFO_DEPTH = 4;

    typedef logic signed [DATA_WIDTH-1:0] fixed_t;

    typedef struct packed {
        logic [NEURON_ID_WIDTH-1:0] id;
        fixed_t                     vmem;
        logic [REFRACT_WIDTH-1:0]   ref_count;
        logic                       spike;
    } neuron_update_t;

    // Integer operand becomes a Qm.n word with an all-zero fraction.
    function automatic fixed_t int_to_fixed(input logic signed [INTEGER_WIDTH-1:0] value);
        return {value, {DATA_WIDTH_FRAC{1'b0}}};
    endfunction

endpackage

// File: rtl/vmem_spike_reset_unit_spike_fifo.sv
// Spike ID queue: power-of-two ring buffer with occupancy count and a sticky drop flag.
// A push into a full queue succeeds only when a pop frees the head slot on the same edge.
module vmem_spike_reset_unit_spike_fifo #(
    parameter int NEURON_ID_WIDTH  = vmem_spike_reset_unit_pkg::NEURON_ID_WIDTH,
    parameter int SPIKE_FIFO_DEPTH = vmem_spike_reset_unit_pkg::SPIKE_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [NEURON_ID_WIDTH-1:0] push_id,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [NEURON_ID_WIDTH-1:0] head,
    output logic                       overflow
);

    localparam int PTR_W = (SPIKE_FIFO_DEPTH > 1) ? $clog2(SPIKE_FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(SPIKE_FIFO_DEPTH + 1);

    logic [NEURON_ID_WIDTH-1:0] mem [SPIKE_FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [CNT_W-1:0]           count;
    logic                       do_push;
    logic                       do_pop;

    assign full    = (count == CNT_W'(SPIKE_FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    // NOTE: non-blocking assignments for all clocked state so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
            if (push && !do_push) overflow <= 1'b1;
        end
    end

    // NOTE: storage array has no reset; head is masked while empty so stale entries never leak out.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_id;
    end

endmodule

// File: rtl/vmem_spike_reset_unit.sv
// Post-leak threshold stage: fire/no-fire decision, Vreset load, refractory update, spike queue.
// Build option: REFRACTORY_EN enables the refractory rule; otherwise out_ref_count is tied to 0.
module vmem_spike_reset_unit
    import vmem_spike_reset_unit_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic signed [INTEGER_WIDTH-1:0] vth,
    input  logic signed [INTEGER_WIDTH-1:0] vreset,
    input  logic [REFRACT_WIDTH-1:0]        tref,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NEURON_ID_WIDTH-1:0]      in_neuron_id,
    input  logic [DATA_WIDTH-1:0]           in_vmem,
    input  logic [REFRACT_WIDTH-1:0]        in_ref_count,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NEURON_ID_WIDTH-1:0]      out_neuron_id,
    output logic [DATA_WIDTH-1:0]           out_vmem,
    output logic [REFRACT_WIDTH-1:0]        out_ref_count,
    output logic                            out_spike,
    output logic                            spike_valid,
    input  logic                            spike_ready,
    output logic [NEURON_ID_WIDTH-1:0]      spike_neuron_id,
    output logic                            spike_overflow
);

    fixed_t         vth_ext;
    fixed_t         vreset_ext;
    neuron_update_t next_upd;
    neuron_update_t out_reg;
    logic           accept;
    logic           fifo_empty;
    logic           fifo_full_unused;

    assign vth_ext    = int_to_fixed(vth);
    assign vreset_ext = int_to_fixed(vreset);
    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;

    // NOTE: every field gets a default before the rule chain, so no path can infer a latch.
    always_comb begin
        next_upd.id        = in_neuron_id;
        next_upd.vmem      = in_vmem;
        next_upd.ref_count = '0;
        next_upd.spike     = 1'b0;
`ifdef REFRACTORY_EN
        if (in_ref_count != '0) begin
            next_upd.vmem      = vreset_ext;
            next_upd.ref_count = in_ref_count - REFRACT_WIDTH'(1);
        end else if ($signed(in_vmem) >= vth_ext) begin
            next_upd.vmem      = vreset_ext;
            next_upd.ref_count = tref;
            next_upd.spike     = 1'b1;
        end
`else
        if ($signed(in_vmem) >= vth_ext) begin
            next_upd.vmem  = vreset_ext;
            next_upd.spike = 1'b1;
        end
`endif
    end

`ifndef REFRACTORY_EN
    logic unused_refract;
    assign unused_refract = ^{in_ref_count, tref};
`endif

    // Single-entry output register: a new result may replace the old one on the edge it is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_reg   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_reg   <= next_upd;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_neuron_id = out_reg.id;
    assign out_vmem      = out_reg.vmem;
    assign out_ref_count = out_reg.ref_count;
    assign out_spike     = out_reg.spike;

    vmem_spike_reset_unit_spike_fifo #(
        .NEURON_ID_WIDTH  (NEURON_ID_WIDTH),
        .SPIKE_FIFO_DEPTH (SPIKE_FIFO_DEPTH)
    ) u_spike_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (accept && next_upd.spike),
        .push_id  (in_neuron_id),
        .pop      (spike_ready),
        .full     (fifo_full_unused),
        .empty    (fifo_empty),
        .head     (spike_neuron_id),
        .overflow (spike_overflow)
    );

    assign spike_valid = !fifo_empty;

endmodule

// File: tb/tb_vmem_spike_reset_unit.sv
// Self-checking bench: directed literal cases plus randomized traffic against a queue-based model.
// Expectations follow REFRACTORY_EN the same way the design build does.
module tb_vmem_spike_reset_unit;
    import vmem_spike_reset_unit_pkg::*;

`ifdef REFRACTORY_EN
    localparam bit REFRACT = 1'b1;
`else
    localparam bit REFRACT = 1'b0;
`endif

    logic                            clk = 1'b0;
    logic                            rst_n = 1'b0;
    logic signed [INTEGER_WIDTH-1:0] vth = '0;
    logic signed [INTEGER_WIDTH-1:0] vreset = '0;
    logic [REFRACT_WIDTH-1:0]        tref = '0;
    logic                            in_valid = 1'b0;
    logic                            in_ready;
    logic [NEURON_ID_WIDTH-1:0]      in_neuron_id = '0;
    logic [DATA_WIDTH-1:0]           in_vmem = '0;
    logic [REFRACT_WIDTH-1:0]        in_ref_count = '0;
    logic                            out_valid;
    logic                            out_ready = 1'b1;
    logic [NEURON_ID_WIDTH-1:0]      out_neuron_id;
    logic [DATA_WIDTH-1:0]           out_vmem;
    logic [REFRACT_WIDTH-1:0]        out_ref_count;
    logic                            out_spike;
    logic                            spike_valid;
    logic                            spike_ready = 1'b0;
    logic [NEURON_ID_WIDTH-1:0]      spike_neuron_id;
    logic                            spike_overflow;

    always #5 clk = ~clk;

    vmem_spike_reset_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .vth             (vth),
        .vreset          (vreset),
        .tref            (tref),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_neuron_id    (in_neuron_id),
        .in_vmem         (in_vmem),
        .in_ref_count    (in_ref_count),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_neuron_id   (out_neuron_id),
        .out_vmem        (out_vmem),
        .out_ref_count   (out_ref_count),
        .out_spike       (out_spike),
        .spike_valid     (spike_valid),
        .spike_ready     (spike_ready),
        .spike_neuron_id (spike_neuron_id),
        .spike_overflow  (spike_overflow)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: plain integer arithmetic on the potentials and an SV queue for spike IDs.
    typedef struct {
        bit [7:0] id;
        longint   vmem;
        int       ref_count;
        bit       spike;
    } rec_t;

    bit       m_valid = 1'b0;
    rec_t     m_out = '{default: 0};
    bit [7:0] m_q[$];
    bit       m_ovf = 1'b0;
    bit       cmp_en = 1'b0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_valid = 1'b0;
            m_out   = '{default: 0};
            m_q.delete();
            m_ovf   = 1'b0;
        end else begin
            bit     acc;
            bit     pop;
            longint v;
            longint th;
            longint rs;
            acc = in_valid && (!m_valid || out_ready);
            pop = (m_q.size() != 0) && spike_ready;
            if (pop) void'(m_q.pop_front());
            if (acc) begin
                v  = $signed(in_vmem);
                th = longint'(vth) * 64'sd4294967296;
                rs = longint'(vreset) * 64'sd4294967296;
                m_out.id        = in_neuron_id;
                m_out.vmem      = v;
                m_out.ref_count = 0;
                m_out.spike     = 1'b0;
                if (REFRACT && in_ref_count != 0) begin
                    m_out.vmem      = rs;
                    m_out.ref_count = int'(in_ref_count) - 1;
                end else if (v >= th) begin
                    m_out.vmem      = rs;
                    m_out.ref_count = REFRACT ? int'(tref) : 0;
                    m_out.spike     = 1'b1;
                    if (m_q.size() < SPIKE_FIFO_DEPTH) m_q.push_back(in_neuron_id);
                    else m_ovf = 1'b1;
                end
                m_valid = 1'b1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && cmp_en) begin
            check("in_ready", in_ready, !m_valid || out_ready);
            check("out_valid", out_valid, m_valid);
            check("out_neuron_id", out_neuron_id, m_out.id);
            check("out_vmem", out_vmem, m_out.vmem);
            check("out_ref_count", out_ref_count, m_out.ref_count);
            check("out_spike", out_spike, m_out.spike);
            check("spike_valid", spike_valid, m_q.size() != 0);
            check("spike_neuron_id", spike_neuron_id, (m_q.size() != 0) ? m_q[0] : 8'd0);
            check("spike_overflow", spike_overflow, m_ovf);
        end
    end

    initial begin
        int drain_ids[4];
        drain_ids = '{2, 3, 4, 6};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst out_valid", out_valid, 0);
        check("rst out_vmem", out_vmem, 0);
        check("rst out_ref_count", out_ref_count, 0);
        check("rst out_spike", out_spike, 0);
        check("rst out_neuron_id", out_neuron_id, 0);
        check("rst spike_valid", spike_valid, 0);
        check("rst spike_neuron_id", spike_neuron_id, 0);
        check("rst spike_overflow", spike_overflow, 0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        #1;
        check("rst in_ready", in_ready, 1);

        // Basic fire
        vth = 32'sd10; vreset = 32'sd0; tref = 8'd3;
        in_valid = 1'b1; in_neuron_id = 8'd5; in_vmem = 64'h0000000A_00000000; in_ref_count = 8'd0;
        tick();
        in_valid = 1'b0;
        check("fire out_spike", out_spike, 1);
        check("fire out_vmem", out_vmem, 64'h0);
        check("fire out_ref_count", out_ref_count, REFRACT ? 3 : 0);
        check("fire spike_valid", spike_valid, 1);
        check("fire spike_neuron_id", spike_neuron_id, 5);
        spike_ready = 1'b1;
        tick();
        spike_ready = 1'b0;

        // Just below threshold
        in_valid = 1'b1; in_neuron_id = 8'd6; in_vmem = 64'h00000009_FFFFFFFF;
        tick();
        in_valid = 1'b0;
        check("below out_spike", out_spike, 0);
        check("below out_vmem", out_vmem, 64'h00000009_FFFFFFFF);
        check("below out_ref_count", out_ref_count, 0);
        check("below spike_valid", spike_valid, 0);

        // Negative threshold, signed compare
        vth = -32'sd5;
        in_valid = 1'b1; in_neuron_id = 8'd7; in_vmem = 64'hFFFFFFFB_00000000;
        tick();
        in_valid = 1'b0;
        check("neg out_spike", out_spike, 1);
        check("neg spike_neuron_id", spike_neuron_id, 7);
        spike_ready = 1'b1;
        tick();
        spike_ready = 1'b0;

        // Refractory input
        vth = 32'sd10; vreset = -32'sd3;
        in_valid = 1'b1; in_neuron_id = 8'd8; in_vmem = 64'h00000064_00000000; in_ref_count = 8'd2;
        tick();
        in_valid = 1'b0; in_ref_count = 8'd0;
        check("refr out_spike", out_spike, REFRACT ? 0 : 1);
        check("refr out_vmem", out_vmem, 64'hFFFFFFFD_00000000);
        check("refr out_ref_count", out_ref_count, REFRACT ? 1 : 0);
        spike_ready = 1'b1;
        tick();
        spike_ready = 1'b0;

        // Backpressure: result held, next input waits, then back-to-back
        vreset = 32'sd0; out_ready = 1'b0;
        in_valid = 1'b1; in_neuron_id = 8'd20; in_vmem = 64'h00000001_00000000;
        tick();
        in_neuron_id = 8'd21;
        for (int i = 0; i < 3; i++) begin
            check("bp in_ready", in_ready, 0);
            check("bp out_neuron_id", out_neuron_id, 20);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("b2b first id", out_neuron_id, 21);
        in_neuron_id = 8'd22;
        tick();
        check("b2b second id", out_neuron_id, 22);
        in_valid = 1'b0;
        tick();
        check("drop out_valid", out_valid, 0);

        // Queue overflow then push-while-full-with-pop
        vth = 32'sd0;
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1; in_neuron_id = 8'(i); in_vmem = 64'h00000001_00000000;
            tick();
        end
        in_valid = 1'b0;
        check("ovf flag", spike_overflow, 1);
        check("ovf head", spike_neuron_id, 1);
        in_valid = 1'b1; in_neuron_id = 8'd6; spike_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("drain order", spike_neuron_id, drain_ids[i]);
            tick();
        end
        check("drain empty", spike_valid, 0);
        spike_ready = 1'b0;

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            int d;
            int vi;
            d  = int'($urandom_range(0, 4)) - 2;
            vth = 32'($urandom_range(0, 20)) - 32'sd10;
            vi = int'(vth) + d;
            vreset = 32'($urandom_range(0, 8)) - 32'sd4;
            tref = 8'($urandom_range(0, 7));
            in_valid = ($urandom % 4) != 0;
            out_ready = ($urandom % 4) != 0;
            spike_ready = ($urandom % 3) != 0;
            in_neuron_id = 8'($urandom);
            in_ref_count = (($urandom % 4) == 0) ? 8'($urandom_range(1, 3)) : 8'd0;
            case ($urandom % 3)
                0: in_vmem = {vi, 32'h0};
                1: in_vmem = {vi, 32'hFFFFFFFF};
                default: in_vmem = {vi, 32'($urandom)};
            endcase
            tick();
        end

        // Asynchronous reset with a pending result and queued spikes
        in_valid = 1'b0; out_ready = 1'b1; spike_ready = 1'b0; in_ref_count = 8'd0;
        tick();
        out_ready = 1'b0; vth = 32'sd0;
        in_valid = 1'b1; in_neuron_id = 8'd9; in_vmem = 64'h00000001_00000000;
        tick();
        in_valid = 1'b0;
        check("pre-rst out_valid", out_valid, 1);
        check("pre-rst spike_valid", spike_valid, 1);
        check("pre-rst overflow", spike_overflow, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async out_valid", out_valid, 0);
        check("async spike_valid", spike_valid, 0);
        check("async overflow", spike_overflow, 0);
        check("async spike_id", spike_neuron_id, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        check("post-rst out_valid", out_valid, 0);
        check("post-rst in_ready", in_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
